// File: rtl/idli_sqr_m.sv
// Instruction sequencer for the idli nibble-serial core: walks ADDR/WAIT/DATA/EXEC,
// gates the PC clock, streams the fetch address and assembles the 16-bit instruction.
module idli_sqr_m (
  input  logic        i_sqr_gck,
  input  logic        i_sqr_rst,
  input  logic        i_sqr_halt,
  input  logic [3:0]  i_sqr_pc_q,
  input  logic        i_sqr_mem_rdy,
  input  logic [3:0]  i_sqr_mem_data,
  output logic [3:0]  o_sqr_mem_addr,
  output logic        o_sqr_mem_addr_vld,
  output logic        o_sqr_pc_en,
  output logic        o_sqr_ctr_last_cycle,
  output logic [1:0]  o_sqr_ctr,
  output logic        o_sqr_core_en,
  output logic [15:0] o_sqr_instr,
  output logic        o_sqr_halted
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DATA,
    ST_EXEC,
    ST_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ctr_q, ctr_d;
  logic [15:0] instr_q;
  logic        ctr_wrap;
  logic        counting;

  assign ctr_wrap = (ctr_q == 2'd3);

  // NOTE: state_d and ctr_d are given defaults first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = i_sqr_halt ? ST_HALT : ST_ADDR;
      ST_ADDR: if (ctr_wrap) state_d = ST_WAIT;
      ST_WAIT: if (i_sqr_mem_rdy) state_d = ST_DATA;
      ST_DATA: if (ctr_wrap) state_d = ST_EXEC;
      ST_EXEC: if (ctr_wrap) state_d = i_sqr_halt ? ST_HALT : ST_ADDR;
      ST_HALT: if (!i_sqr_halt) state_d = ST_ADDR;
      default: state_d = ST_IDLE;
    endcase

    // The 3->0 wrap always coincides with a state change, so staying put means ctr < 3.
    counting = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_EXEC);
    ctr_d    = 2'd0;
    if (counting && (state_d == state_q)) ctr_d = ctr_q + 2'd1;
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge i_sqr_gck) begin
    if (i_sqr_rst) begin
      state_q              <= ST_IDLE;
      ctr_q                <= 2'd0;
      instr_q              <= 16'h0000;
      o_sqr_mem_addr_vld   <= 1'b0;
      o_sqr_pc_en          <= 1'b0;
      o_sqr_ctr_last_cycle <= 1'b0;
      o_sqr_core_en        <= 1'b0;
      o_sqr_halted         <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      // First nibble captured ends up in instr[3:0] after four shifts.
      if (state_q == ST_DATA) instr_q <= {i_sqr_mem_data, instr_q[15:4]};
      // Outputs are decoded from the next state so they line up with state_q.
      o_sqr_mem_addr_vld   <= (state_d == ST_ADDR);
      o_sqr_pc_en          <= (state_d == ST_ADDR);
      o_sqr_ctr_last_cycle <= (state_d == ST_ADDR) && (ctr_d == 2'd3);
      o_sqr_core_en        <= (state_d == ST_EXEC);
      o_sqr_halted         <= (state_d == ST_HALT);
    end
  end

  assign o_sqr_ctr      = ctr_q;
  assign o_sqr_instr    = instr_q;
  assign o_sqr_mem_addr = o_sqr_mem_addr_vld ? i_sqr_pc_q : 4'h0;

endmodule

// File: doc/idli_sqr_m.md
# idli_sqr_m

Instruction sequencer for the idli nibble-serial core. It decides when the PC's gated clock ticks, when the PC's 4-bit slice is driven out as a fetch address, and when the 16-bit instruction is collected from memory and presented to the execute datapath. It sits between the memory interface and the PC/core. The PC advances exactly once per instruction, during the 4-cycle ADDR window.

## Interface
Parameters:
- none; nibble count per word is fixed at 4, and the 16-bit word width is fixed.

Ports:
- i_sqr_gck  in  1  core clock
- i_sqr_rst  in  1  reset; synchronous, active-high
- i_sqr_halt  in  1  request to stop at the next instruction boundary
- i_sqr_pc_q  in  4  current PC nibble from the PC block
- i_sqr_mem_rdy  in  1  memory has the addressed word ready to stream
- i_sqr_mem_data  in  4  instruction nibble from memory, valid in DATA
- o_sqr_mem_addr  out  4  address nibble to memory (= i_sqr_pc_q in ADDR, else 0)
- o_sqr_mem_addr_vld  out  1  address nibble valid
- o_sqr_pc_en  out  1  PC clock enable
- o_sqr_ctr_last_cycle  out  1  drives the PC block's last-cycle input
- o_sqr_ctr  out  2  nibble index within the current window
- o_sqr_core_en  out  1  execute datapath enable
- o_sqr_instr  out  16  assembled instruction
- o_sqr_halted  out  1  sequencer is parked in HALT

## Operation
- States: IDLE, ADDR, WAIT, DATA, EXEC, HALT.
  - Counter ctr: 2 bits.
  - Instruction register: 16 bits.
- IDLE (entered on reset):
  - All enables are low.
  - Next state is HALT if i_sqr_halt=1, else ADDR.
- ADDR, 4 cycles, ctr 0..3:
  - o_sqr_pc_en=1, o_sqr_mem_addr_vld=1, o_sqr_mem_addr=i_sqr_pc_q.
  - Nibbles go out LSB first.
  - o_sqr_ctr_last_cycle=1 only at ctr=3.
  - After ctr=3, go to WAIT.
- WAIT:
  - All enables are low, and ctr is held at 0.
  - i_sqr_mem_rdy is sampled only in WAIT. When it is 1, go to DATA on the next cycle.
  - WAIT always lasts at least 1 cycle.
- DATA, 4 cycles:
  - Each cycle: instr <= {i_sqr_mem_data, instr[15:4]}, so the first nibble lands in instr[3:0].
  - After ctr=3, go to EXEC.
- EXEC, 4 cycles:
  - o_sqr_core_en=1, and instr is held.
  - At ctr=3: go to HALT if i_sqr_halt=1, else ADDR.
- HALT:
  - o_sqr_halted=1, and all enables are low.
  - When i_sqr_halt=0, go to ADDR.
- ctr rules:
  - Increments mod 4 in ADDR, DATA and EXEC.
  - Forced to 0 on every state change, and in IDLE, WAIT and HALT.
  - Wrap from 3 to 0 coincides with the state transition.
- All outputs are registered state decodes except o_sqr_mem_addr, which is a combinational pass-through of i_sqr_pc_q gated by the ADDR decode.
- o_sqr_ctr_last_cycle is never asserted outside ADDR. The PC therefore only reloads its +2 increment inside its own clocked window.

## Timing
- Reset values:
  - state=IDLE, ctr=0, instr=0x0000.
  - o_sqr_pc_en=0, o_sqr_mem_addr_vld=0, o_sqr_mem_addr=0, o_sqr_ctr_last_cycle=0, o_sqr_core_en=0, o_sqr_halted=0, o_sqr_ctr=0.
- Reset asserted mid-operation in any state: the next edge returns to IDLE. instr is cleared and any partial word is discarded.
- Instruction period is 13 + (WAIT cycles - 1): ADDR 4, WAIT ≥1, DATA 4, EXEC 4.
- o_sqr_instr is stable for all 4 EXEC cycles and through the following ADDR/WAIT/DATA until it is overwritten.
- Halt:
  - Sampled only in IDLE and at EXEC ctr=3.
  - A pulse outside those points is ignored.
  - An instruction in flight always completes.
- i_sqr_mem_rdy high in ADDR or DATA is ignored.
- i_sqr_mem_rdy dropping during DATA is ignored; memory must stream 4 consecutive nibbles.
- Simultaneous i_sqr_halt=1 and i_sqr_mem_rdy=1 in WAIT: go to DATA. Halt is honoured at the end of EXEC.

## Test plan
- Reset release with halt=0 and mem_rdy tied 1 → IDLE 1 cycle, then:
  - ADDR addr_vld for 4 cycles with last_cycle on the 4th;
  - WAIT 1 cycle;
  - DATA streaming 0x1,0x2,0x3,0x4 → o_sqr_instr=0x4321;
  - core_en high for exactly 4 cycles;
  - period of 13 cycles.
- PC block attached with rst cleared:
  - first ADDR emits 0,0,0,0;
  - second ADDR emits 2,0,0,0;
  - third emits 4,0,0,0;
  - pc_en high for exactly 4 cycles per instruction.
- mem_rdy held low 5 cycles into WAIT → pc_en, core_en and addr_vld all stay 0, ctr=0; DATA starts the cycle after rdy=1.
- halt raised mid-DATA → the instruction completes its EXEC, then HALT with halted=1; halt dropped → ADDR next cycle.
- Reset asserted at DATA ctr=2 → next cycle IDLE, instr=0, all outputs 0; the following fetch assembles cleanly.
- halt pulsed for 1 cycle during ADDR → ignored; the sequence proceeds to WAIT.
